// File: rtl/player_pkg.sv
// Shared types and default widths for the sample playback path.
package player_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sample_player_tick.sv
// Free-running modulo counter that marks the last cycle of every sample period.
module tick_divider #(
    parameter int unsigned TICK_DIV = 1134
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count: clear restarts the period, otherwise wrap at CNT_MAX.
    always_comb begin
        cnt_next = cnt;
        if (i_clr) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Counter and registered tick (tick is high while the count sits at CNT_MAX).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            o_tick <= (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: rtl/sample_player.sv
// Plays stored samples from address 0, one per sample period, single-shot or looping.
module sample_player #(
    parameter int unsigned ADDR_W   = player_pkg::ADDR_W,
    parameter int unsigned DATA_W   = player_pkg::DATA_W,
    parameter int unsigned TICK_DIV = 1134
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    import player_pkg::*;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic [DATA_W-1:0] prefetch;

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] len_d;
    logic              loop_d;
    logic [DATA_W-1:0] prefetch_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              done_d;
    logic              rd_d;
    logic              busy_d;

    logic              tick;
    logic              accept;
    logic              is_last;
    logic              tick_hit;

    assign accept   = (state == IDLE) && i_start && !i_stop && (i_len != '0);
    assign is_last  = (o_addr == (len_q - ADDR_W'(1)));
    assign tick_hit = (state == HOLD) && tick && !i_stop;

    // Sample-period timebase, re-phased on every accepted start.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (accept),
        .o_tick (tick)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; stop overrides every transition out of a busy state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = FETCH;
            FETCH: next_state = WAIT;
            WAIT:  next_state = HOLD;
            HOLD: begin
                if (tick) begin
                    next_state = (is_last && !loop_q) ? DONE : FETCH;
                end
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if ((state != IDLE) && i_stop) begin
            next_state = IDLE;
        end
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        addr_d     = o_addr;
        len_d      = len_q;
        loop_d     = loop_q;
        prefetch_d = prefetch;
        data_d     = o_data;
        rd_d       = (next_state == FETCH);
        busy_d     = (state != IDLE);
        valid_d    = tick_hit;
        done_d     = (state == DONE) && !i_stop;

        if (accept) begin
            addr_d = '0;
            len_d  = i_len;
            loop_d = i_loop;
        end

        if (state == WAIT) begin
            prefetch_d = i_data;
        end

        if (tick_hit) begin
            data_d = prefetch;
            if (!is_last) begin
                addr_d = o_addr + ADDR_W'(1);
            end else if (loop_q) begin
                addr_d = '0;
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_addr   <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            prefetch <= '0;
            o_data   <= '0;
            o_rd     <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_addr   <= addr_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            prefetch <= prefetch_d;
            o_data   <= data_d;
            o_rd     <= rd_d;
            o_busy   <= busy_d;
            o_valid  <= valid_d;
            o_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_sample_player.sv
// Scoreboard bench for sample_player: stimulus pushes expected events, a monitor pops and checks.
module tb_sample_player;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int TD  = 4;
    localparam int INF = 32'h3fff_ffff;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic              i_stop;
    logic              i_loop;
    logic [ADDR_W-1:0] i_len;
    logic [ADDR_W-1:0] o_addr;
    logic              o_rd;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_done;

    sample_player #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TD)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_loop  (i_loop),
        .i_len   (i_len),
        .o_addr  (o_addr),
        .o_rd    (o_rd),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    typedef struct {
        int cyc;
        int data;
        bit is_done;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  busy_lo = INF;
    int  busy_hi = -1;
    int  cur_len = 0;
    int  rd_idx = 0;
    int  rds = 0;
    int  last_exp = 0;
    bit  mon_en = 0;
    bit  prev_rd = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Sample memory: mem[a] = a + 0x10, data valid the cycle after the read strobe.
    always @(posedge i_clk) begin
        if (o_rd) i_data <= o_addr[7:0] + 8'h10;
    end

    function automatic int mem(input int a);
        logic [7:0] v;
        v = 8'(a) + 8'h10;
        return int'(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: match output events against the scoreboard and police the read port.
    always @(negedge i_clk) begin
        ev_t ev;
        if (mon_en) begin
            while (q.size() != 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: got none expected %s at cycle %0d (now %0d)",
                         q[0].is_done ? "done" : "valid", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (o_valid || o_done) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    chk("event_time", cyc, (q.size() != 0) ? q[0].cyc : -1);
                end else begin
                    ev = q.pop_front();
                    chk("event_kind_done", int'(o_done), int'(ev.is_done));
                    if (!ev.is_done) chk("sample_data", int'(o_data), ev.data);
                end
            end
            if (o_valid) begin
                chk("rd_per_valid", rds, 1);
                rds = 0;
            end
            chk("busy", int'(o_busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (o_rd) begin
                chk("rd_single", int'(prev_rd), 0);
                chk("rd_window", (cyc >= busy_lo - 1 && cyc < busy_hi) ? 1 : 0, 1);
                if (cur_len > 0) chk("rd_addr", int'(o_addr), rd_idx % cur_len);
                rd_idx++;
                rds++;
            end
            prev_rd = o_rd;
        end else begin
            prev_rd = 0;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One idle-or-pulse cycle; pulses i_start only while the player must ignore it.
    task automatic step_pulse(input bit pulses);
        if (pulses && ($urandom % 4 == 0) && (cyc + 1 >= busy_lo) && (cyc + 1 <= busy_hi)) begin
            i_start = 1'b1;
            i_len   = ADDR_W'($urandom_range(0, 9));
            i_loop  = 1'($urandom);
            step();
            i_start = 1'b0;
        end else begin
            step();
        end
    endtask

    // Issue a start and load the scoreboard with the expected playback; returns t0 and event count.
    task automatic arm(input int len, input bit lp, input bit start_stop,
                       output int t0, output int nev);
        int te;
        t0 = cyc + 1;
        nev = 0;
        i_start = 1'b1;
        i_len   = ADDR_W'(len);
        i_loop  = lp;
        i_stop  = start_stop;
        rd_idx  = 0;
        rds     = 0;
        cur_len = len;
        if (!start_stop && len != 0) begin
            nev = lp ? 40 : len;
            for (int k = 0; k < nev; k++) q.push_back('{t0 + TD * (k + 1), mem(k % len), 1'b0});
            te = lp ? INF : t0 + TD * len + 1;
            if (!lp) q.push_back('{te, 0, 1'b1});
            busy_lo = t0 + 1;
            busy_hi = te;
        end
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_len   = ADDR_W'($urandom);
        i_loop  = 1'($urandom);
    endtask

    task automatic run(input int len, input bit lp, input int stop_k,
                       input bit start_stop, input bit pulses);
        int t0, nev, s, nvalid, budget;
        arm(len, lp, start_stop, t0, nev);
        s = INF;
        if (stop_k >= 0) begin
            repeat (stop_k) step_pulse(pulses);
            i_stop = 1'b1;
            s = cyc + 1;
            while (q.size() != 0 && q[$].cyc >= s) void'(q.pop_back());
            if (busy_hi > s) busy_hi = s;
            step();
            i_stop = 1'b0;
        end
        budget = 0;
        while ((q.size() != 0 || cyc <= busy_hi) && budget < 300) begin
            step_pulse(pulses && stop_k < 0);
            budget++;
        end
        if (budget >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending events expected 0", q.size());
            q.delete();
        end
        step();
        nvalid = 0;
        for (int k = 0; k < nev; k++) if (t0 + TD * (k + 1) < s) nvalid++;
        if (nvalid > 0) last_exp = mem((nvalid - 1) % len);
        chk("final_data", int'(o_data), last_exp);
        chk("final_busy", int'(o_busy), 0);
        busy_lo = INF;
        busy_hi = -1;
        repeat (2) step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_data"},  int'(o_data), 0);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_done"},  int'(o_done), 0);
        chk({tag, "_rd"},    int'(o_rd), 0);
        chk({tag, "_addr"},  int'(o_addr), 0);
    endtask

    initial begin
        int t0, nev, len, stop_k;
        bit lp;
        i_rst = 1'b0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_loop = 1'b0;
        i_len = '0;
        repeat (3) step();
        chk_zero_outputs("reset");
        i_rst = 1'b1;
        step();
        mon_en = 1;

        run(3, 1'b0, -1, 1'b0, 1'b0);
        chk("basic_last", int'(o_data), 8'h12);
        run(2, 1'b1, 17, 1'b0, 1'b0);
        run(5, 1'b0, 8, 1'b0, 1'b0);
        chk("stop_hold", int'(o_data), 8'h11);
        run(0, 1'b0, -1, 1'b0, 1'b0);
        run(3, 1'b0, -1, 1'b1, 1'b0);
        run(4, 1'b0, -1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a playback.
        arm(4, 1'b0, 1'b0, t0, nev);
        repeat (5) step();
        mon_en = 0;
        i_rst = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        q.delete();
        busy_lo = INF;
        busy_hi = -1;
        last_exp = 0;
        repeat (2) step();
        i_rst = 1'b1;
        step();
        mon_en = 1;
        run(3, 1'b0, -1, 1'b0, 1'b0);

        // Randomized playbacks.
        for (int r = 0; r < 25; r++) begin
            len = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 6));
            lp = 1'($urandom);
            if (lp) stop_k = int'($urandom_range(0, 40));
            else    stop_k = ($urandom % 2 == 0) ? int'($urandom_range(0, 30)) : -1;
            run(len, lp, stop_k, ($urandom % 10 == 0), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
